// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-stage launch, stall and result handshake for the multiply/divide unit
interface ex_muldiv_if #(parameter int WIDTH = 32);
   logic             start;
   logic [2:0]       funct3;
   logic [WIDTH-1:0] op_a;
   logic [WIDTH-1:0] op_b;
   logic             flush;
   logic             stall;
   logic             done;
   logic [WIDTH-1:0] result;
   modport master (output start, funct3, op_a, op_b, flush, input stall, done, result);
   modport slave (input start, funct3, op_a, op_b, flush, output stall, done, result);
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: iterative RV32M multiply/divide unit that stalls the pipeline while it iterates
module ex_muldiv #(parameter int WIDTH = 32) (
   input logic        clk,
   input logic        rst,
   ex_muldiv_if.slave bus
);
   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
   state_t             state;
   logic [5:0]         cnt;
   logic [2*WIDTH-1:0] acc, acc_nxt, prod;
   logic [WIDTH-1:0]   opnd, abs_a, abs_b, spec_res, quo, rem, res_nxt, result_r;
   logic [WIDTH:0]     sum, diff;
   logic [2:0]         f3;
   logic               neg_a, neg_b, sgn_a, sgn_b, is_div, b_zero, ovf, special, launch, done_r;
   // Operand decode at launch and one multiply or divide step on the held operands
   always_comb begin
      sgn_a    = (bus.funct3 == 3'd1 || bus.funct3 == 3'd2 || bus.funct3 == 3'd4 || bus.funct3 == 3'd6) && bus.op_a[WIDTH-1];
      sgn_b    = (bus.funct3 == 3'd1 || bus.funct3 == 3'd4 || bus.funct3 == 3'd6) && bus.op_b[WIDTH-1];
      abs_a    = sgn_a ? -bus.op_a : bus.op_a;
      abs_b    = sgn_b ? -bus.op_b : bus.op_b;
      is_div   = bus.funct3[2];
      b_zero   = bus.op_b == '0;
      ovf      = is_div && !bus.funct3[0] && (bus.op_a == {1'b1, {(WIDTH-1){1'b0}}}) && (&bus.op_b);
      special  = is_div && (b_zero || ovf);
      spec_res = bus.funct3[1] ? (b_zero ? bus.op_a : '0) : (b_zero ? '1 : bus.op_a);
      launch   = state == IDLE && bus.start && !bus.flush;
      sum      = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
      diff     = acc[2*WIDTH-1:WIDTH-1] - {1'b0, opnd};
      acc_nxt  = f3[2] ? (diff[WIDTH] ? {acc[2*WIDTH-2:0], 1'b0} : {diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1}) : {sum, acc[WIDTH-1:1]};
      prod     = (neg_a ^ neg_b) ? -acc_nxt : acc_nxt;
      quo      = (neg_a ^ neg_b) ? -acc_nxt[WIDTH-1:0] : acc_nxt[WIDTH-1:0];
      rem      = neg_a ? -acc_nxt[2*WIDTH-1:WIDTH] : acc_nxt[2*WIDTH-1:WIDTH];
      res_nxt  = f3 == 3'd0 ? prod[WIDTH-1:0] : !f3[2] ? prod[2*WIDTH-1:WIDTH] : f3[1] ? rem : quo;
   end
   assign bus.stall  = launch || state == CALC;
   assign bus.done   = done_r;
   assign bus.result = result_r;
   // Control FSM: launch or fast-path in IDLE, iterate in CALC, single done pulse
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state    <= IDLE;
         cnt      <= '0;
         acc      <= '0;
         opnd     <= '0;
         f3       <= '0;
         neg_a    <= 1'b0;
         neg_b    <= 1'b0;
         done_r   <= 1'b0;
         result_r <= '0;
      end else begin
         done_r <= 1'b0;
         case (state)
            IDLE: if (launch) begin
               f3    <= bus.funct3;
               neg_a <= sgn_a;
               neg_b <= sgn_b;
               opnd  <= is_div ? abs_b : abs_a;
               acc   <= {{WIDTH{1'b0}}, is_div ? abs_a : abs_b};
               cnt   <= 6'(WIDTH);
               if (special) begin
                  result_r <= spec_res;
                  done_r   <= 1'b1;
                  state    <= DONE;
               end else state <= CALC;
            end
            CALC: if (bus.flush) state <= IDLE;
            else begin
               acc <= acc_nxt;
               cnt <= cnt - 6'd1;
               if (cnt == 6'd1) begin
                  result_r <= res_nxt;
                  done_r   <= 1'b1;
                  state    <= DONE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed checks of ex_muldiv against an arithmetic reference model
module tb_ex_muldiv;
   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   errors = 0;
   ex_muldiv_if #(.WIDTH(32)) bus ();
   ex_muldiv #(.WIDTH(32)) dut (.clk(clk), .rst(rst), .bus(bus));
   always #5 clk = ~clk;
   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask
   function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic signed [63:0] ax, bx;
      logic [63:0] p;
      int sa, sb;
      ax = (f == 3'd1 || f == 3'd2) ? {{32{a[31]}}, a} : {32'd0, a};
      bx = (f == 3'd1) ? {{32{b[31]}}, b} : {32'd0, b};
      p = ax * bx;
      sa = a;
      sb = b;
      case (f)
         3'd0: return p[31:0];
         3'd1, 3'd2, 3'd3: return p[63:32];
         3'd4: return b == 0 ? 32'hFFFFFFFF : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'h80000000 : 32'(sa / sb);
         3'd5: return b == 0 ? 32'hFFFFFFFF : a / b;
         3'd6: return b == 0 ? a : (a == 32'h80000000 && b == 32'hFFFFFFFF) ? 32'd0 : 32'(sa % sb);
         default: return b == 0 ? a : a % b;
      endcase
   endfunction
   function automatic logic [31:0] pick();
      case ($urandom_range(0, 5))
         0: return 32'd0;
         1: return 32'h80000000;
         2: return 32'hFFFFFFFF;
         3: return 32'($urandom_range(0, 20));
         default: return 32'($urandom);
      endcase
   endfunction
   task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      logic [31:0] exp;
      int exp_lat, lat;
      exp = model(f, a, b);
      exp_lat = (f[2] && (b == 0 || ((f == 3'd4 || f == 3'd6) && a == 32'h80000000 && b == 32'hFFFFFFFF))) ? 1 : 33;
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = f; bus.op_a = a; bus.op_b = b;
      #1 check("stall_launch", 32'(bus.stall), 1);
      @(negedge clk);
      bus.start = 1'b0;
      lat = 1;
      while (!bus.done && lat < 40) begin
         check("stall_busy", 32'(bus.stall), 1);
         @(negedge clk);
         lat++;
      end
      check($sformatf("latency f%0d", f), lat, exp_lat);
      check("stall_done", 32'(bus.stall), 0);
      check($sformatf("result f%0d %h %h", f, a, b), bus.result, exp);
      @(negedge clk);
      check("done_single", 32'(bus.done), 0);
      check("result_hold", bus.result, exp);
   endtask
   initial begin
      int seen;
      bus.start = 1'b0; bus.funct3 = '0; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
      #2;
      check("rst_stall", 32'(bus.stall), 0);
      check("rst_done", 32'(bus.done), 0);
      check("rst_result", bus.result, 0);
      @(negedge clk);
      rst = 1'b1;
      run_op(3'd0, 32'd7, 32'd6);
      run_op(3'd1, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op(3'd3, 32'hFFFFFFFF, 32'hFFFFFFFF);
      run_op(3'd2, 32'hFFFFFFFF, 32'd2);
      run_op(3'd4, -32'd7, 32'd2);
      run_op(3'd6, -32'd7, 32'd2);
      run_op(3'd5, 32'd100, 32'd7);
      run_op(3'd7, 32'd100, 32'd7);
      run_op(3'd4, 32'd5, 32'd0);
      run_op(3'd7, 32'd5, 32'd0);
      run_op(3'd4, 32'h80000000, 32'hFFFFFFFF);
      run_op(3'd6, 32'h80000000, 32'hFFFFFFFF);
      run_op(3'd5, 32'h80000000, 32'hFFFFFFFF);
      run_op(3'd1, 32'h80000000, 32'h80000000);
      run_op(3'd4, 32'd1000, 32'd3);
      // start with flush in IDLE must not launch
      @(negedge clk);
      bus.start = 1'b1; bus.flush = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd9; bus.op_b = 32'd9;
      #1 check("idle_flush_stall", 32'(bus.stall), 0);
      @(negedge clk);
      bus.start = 1'b0; bus.flush = 1'b0;
      check("idle_flush_stall2", 32'(bus.stall), 0);
      check("idle_flush_done", 32'(bus.done), 0);
      @(negedge clk);
      check("idle_flush_done2", 32'(bus.done), 0);
      check("idle_flush_result", bus.result, 32'd333);
      // flush of a DIV in cycle 10, then MUL from cycle 12
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'd4; bus.op_a = 32'd5000; bus.op_b = 32'd7;
      repeat (10) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      bus.flush = 1'b1;
      #1 check("flush_stall10", 32'(bus.stall), 1);
      @(negedge clk);
      bus.flush = 1'b0;
      #1 check("flush_stall11", 32'(bus.stall), 0);
      check("flush_done11", 32'(bus.done), 0);
      check("flush_result", bus.result, 32'd333);
      run_op(3'd0, 32'd12345, 32'd678);
      // asynchronous reset in cycle 15 of a MUL
      @(negedge clk);
      bus.start = 1'b1; bus.funct3 = 3'd0; bus.op_a = 32'd3; bus.op_b = 32'd5;
      repeat (15) begin
         @(negedge clk);
         bus.start = 1'b0;
      end
      #1 rst = 1'b0;
      #1;
      check("arst_stall", 32'(bus.stall), 0);
      check("arst_done", 32'(bus.done), 0);
      check("arst_result", bus.result, 0);
      @(negedge clk);
      rst = 1'b1;
      seen = 0;
      repeat (36) begin
         @(negedge clk);
         if (bus.done) seen++;
      end
      check("arst_no_done", seen, 0);
      run_op(3'd3, 32'hDEADBEEF, 32'h12345678);
      for (int i = 0; i < 40; i++) run_op(3'($urandom_range(0, 7)), pick(), pick());
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
